// File: rtl/hidden_layer_seq.sv
// Hidden-layer sequencer: walks the weight ROM and input RAM, accumulates signed w*x per
// neuron and emits one accumulator result per hidden neuron.
module hidden_layer_seq #(
    parameter int unsigned N_IN  = 784,
    parameter int unsigned N_HID = 32,
    parameter int unsigned AW    = 15,
    parameter int unsigned XW    = 10,
    parameter int unsigned HW    = 5,
    parameter int unsigned ACCW  = 26
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [AW-1:0]          w_addr,
    input  logic [7:0]             w_q,
    output logic [XW-1:0]          x_addr,
    input  logic [7:0]             x_q,
    output logic                   busy,
    output logic                   h_valid,
    output logic [HW-1:0]          h_idx,
    output logic signed [ACCW-1:0] h_acc,
    output logic                   done
);

    localparam logic [XW-1:0] XLast = XW'(N_IN - 1);
    localparam logic [HW-1:0] HLast = HW'(N_HID - 1);
    localparam logic [AW-1:0] WLast = AW'(N_IN * N_HID - 1);

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StEmit, StDone} state_e;

    state_e                 state;
    logic [HW-1:0]          h;
    logic                   iss;
    logic signed [ACCW-1:0] acc;
    logic signed [15:0]     prod;
    logic signed [ACCW-1:0] acc_nxt;

    always_comb begin
        prod    = $signed(w_q) * $signed(x_q);
        acc_nxt = acc + $signed({{(ACCW-16){prod[15]}}, prod});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= StIdle;
            h       <= '0;
            iss     <= 1'b0;
            acc     <= '0;
            w_addr  <= '0;
            x_addr  <= '0;
            busy    <= 1'b0;
            h_valid <= 1'b0;
            h_idx   <= '0;
            h_acc   <= '0;
            done    <= 1'b0;
        end else begin
            // ROM/RAM data lags the address by one cycle; iss marks it as live
            iss     <= (state == StRun);
            h_valid <= 1'b0;
            done    <= 1'b0;
            if (iss) begin
                acc <= acc_nxt;
            end
            case (state)
                StIdle: begin
                    if (start) begin
                        state  <= StRun;
                        busy   <= 1'b1;
                        h      <= '0;
                        w_addr <= '0;
                        x_addr <= '0;
                        acc    <= '0;
                    end
                end
                StRun: begin
                    if (x_addr == XLast) begin
                        x_addr <= '0;
                        state  <= StDrain;
                        // Stop on the final weight so the address never leaves the ROM
                        if (w_addr != WLast) begin
                            w_addr <= w_addr + 1'b1;
                        end
                    end else begin
                        x_addr <= x_addr + 1'b1;
                        w_addr <= w_addr + 1'b1;
                    end
                end
                StDrain: begin
                    // Last product folded in here so h_valid lines up with the EMIT cycle
                    h_acc   <= acc_nxt;
                    h_idx   <= h;
                    h_valid <= 1'b1;
                    state   <= StEmit;
                end
                StEmit: begin
                    acc <= '0;
                    if (h == HLast) begin
                        state <= StDone;
                        done  <= 1'b1;
                    end else begin
                        h     <= h + 1'b1;
                        state <= StRun;
                    end
                end
                StDone: begin
                    w_addr <= '0;
                    x_addr <= '0;
                    busy   <= 1'b0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hidden_layer_seq.sv
// Bench for hidden_layer_seq: ROM/RAM models, scoreboard of per-neuron dot products and
// a monitor that pops and compares on every h_valid.
module tb_hidden_layer_seq;

    localparam int NIN  = 784;
    localparam int NHID = 32;
    localparam int NW   = NIN * NHID;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [14:0]        w_addr;
    logic [7:0]         w_q;
    logic [9:0]         x_addr;
    logic [7:0]         x_q;
    logic               busy;
    logic               h_valid;
    logic [4:0]         h_idx;
    logic signed [25:0] h_acc;
    logic               done;

    hidden_layer_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .w_addr  (w_addr),
        .w_q     (w_q),
        .x_addr  (x_addr),
        .x_q     (x_q),
        .busy    (busy),
        .h_valid (h_valid),
        .h_idx   (h_idx),
        .h_acc   (h_acc),
        .done    (done)
    );

    always #5 clk = ~clk;

    byte rom [NW];
    byte ram [NIN];

    // Registered-read memories, one cycle of latency
    always @(posedge clk) begin
        w_q <= (int'(w_addr) < NW) ? rom[w_addr] : 8'h00;
        x_q <= (int'(x_addr) < NIN) ? ram[x_addr] : 8'h00;
    end

    int      total = 0;
    int      bad   = 0;
    int      exp_idx [$];
    longint  exp_acc [$];
    longint  last_acc = 0;
    int      pops = 0;
    int      done_cnt = 0;
    int      wraps = 0;
    int      max_w = 0;
    int      x_prev = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 25) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain dot product of each neuron's weight row with the input vector
    task automatic push_expected();
        for (int h = 0; h < NHID; h++) begin
            longint s = 0;
            for (int i = 0; i < NIN; i++) s += longint'(rom[h*NIN + i]) * longint'(ram[i]);
            exp_idx.push_back(h);
            exp_acc.push_back(s);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            last_acc = 0;
            x_prev   = 0;
        end else begin
            if (x_prev == NIN - 1 && int'(x_addr) == 0) wraps++;
            x_prev = int'(x_addr);
            if (int'(w_addr) > max_w) max_w = int'(w_addr);
            if (done) done_cnt++;
            if (h_valid) begin
                pops++;
                if (exp_acc.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_h_valid: got idx %0d acc %0d with empty queue",
                             h_idx, h_acc);
                end else begin
                    int     ei;
                    longint ea;
                    ei = exp_idx.pop_front();
                    ea = exp_acc.pop_front();
                    chk("h_idx", longint'(h_idx), longint'(ei));
                    chk("h_acc", longint'(h_acc), ea);
                end
                last_acc = longint'(h_acc);
            end else begin
                chk("h_acc_hold", longint'(h_acc), last_acc);
            end
        end
    end

    // One full layer pass; abort_at > 0 asserts reset at that cycle instead of finishing
    task automatic run_pass(input bit timing, input int abort_at);
        int  first_hv;
        bit  seen;
        first_hv = -1;
        seen     = 1'b0;
        wraps    = 0;
        max_w    = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;   // cycle 1: RUN
        chk("busy_in_run", longint'(busy), 1);
        for (int k = 2; k <= 26000; k++) begin
            @(negedge clk);
            if (timing && k == 1000) start = 1'b1;
            if (timing && k == 1001) start = 1'b0;
            if (timing && k == 3931) begin
                chk("n5_first_w_addr", longint'(w_addr), 3920);
                chk("n5_first_x_addr", longint'(x_addr), 0);
            end
            if (h_valid && first_hv < 0) first_hv = k;
            if (k == abort_at) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (done) begin
                seen = 1'b1;
                if (timing) begin
                    chk("first_h_valid_cycle", first_hv, 786);
                    chk("done_cycle", k, 25153);
                end
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected done within 26000 cycles");
        end
        chk("x_wraps", wraps, 32);
        chk("max_w_addr", max_w, NW - 1);
        chk("queue_empty", exp_acc.size(), 0);
        @(negedge clk);
        chk("busy_after_done", longint'(busy), 0);
    endtask

    initial begin
        int d0;
        int p0;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_h_valid", longint'(h_valid), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_w_addr", longint'(w_addr), 0);
        chk("rst_x_addr", longint'(x_addr), 0);
        chk("rst_h_idx", longint'(h_idx), 0);
        chk("rst_h_acc", longint'(h_acc), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_busy", longint'(busy), 0);
        chk("idle_no_h_valid", pops, 0);

        // All ones: every neuron sums to N_IN; also timing, address trace and mid-run start
        foreach (rom[i]) rom[i] = 8'sh01;
        foreach (ram[i]) ram[i] = 8'sh01;
        push_expected();
        run_pass(1'b1, 0);

        // Most negative times most negative: largest positive sum
        foreach (rom[i]) rom[i] = 8'sh80;
        foreach (ram[i]) ram[i] = 8'sh80;
        push_expected();
        run_pass(1'b0, 0);

        // Random weights for the lower half, -1 for the upper half, inputs all 5
        foreach (rom[i]) rom[i] = (i >= NW / 2) ? 8'shFF : byte'($urandom_range(0, 255));
        foreach (ram[i]) ram[i] = 8'sh05;
        push_expected();
        d0 = done_cnt;
        p0 = pops;
        run_pass(1'b0, 3 * 786 + 400);
        chk("abort_pops", pops - p0, 3);
        chk("abort_no_done", done_cnt - d0, 0);
        exp_idx.delete();
        exp_acc.delete();
        repeat (5) @(negedge clk);
        chk("abort_idle_busy", longint'(busy), 0);
        chk("abort_idle_h_valid", longint'(h_valid), 0);

        push_expected();
        run_pass(1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
